// File: rtl/sec_timer_ctrl.sv
// sec_timer_ctrl: multi-channel seconds-timer controller.
//
// A free-running prescaler produces a one-cycle 1 s tick enable (tick_1s_o).
// N_CH countdown channels share that tick. Each channel is configured through
// a single valid/ready command port. Each channel has a sticky expiry flag and
// a one-cycle done pulse, and irq_o is the OR of all flags.
//
// Ports:
//   clk, rst_n    clock (rising edge), async active-low reset
//   cmd_valid_i   command request, held with its payload until accepted
//   cmd_ready_o   low only in tick cycles
//   cmd_op_i      00 LOAD, 01 PAUSE, 10 RESUME, 11 CLEAR
//   cmd_ch_i      target channel
//   cmd_val_i     seconds for LOAD
//   tick_1s_o     registered 1 s pulse
//   ch_busy_o     channel in RUN or PAUSE
//   ch_done_o     registered one-cycle expiry pulse per channel
//   ch_flag_o     sticky expiry flag per channel
//   irq_o         OR of ch_flag_o
//   rd_ch_i       readback channel select
//   rd_remain_o   remaining seconds of rd_ch_i (combinational)

// ---------------------------------------------------------------------------
// One countdown channel
// ---------------------------------------------------------------------------
module sec_timer_ch #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             cmd_hit_i,
  input  logic [1:0]       cmd_op_i,
  input  logic [CNT_W-1:0] cmd_val_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             flag_o,
  output logic [CNT_W-1:0] remain_o
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} st_e;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  st_e              state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             done_q, done_d;
  logic             flag_q, flag_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      done_q   <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      flag_q   <= flag_d;
    end
  end

  // Next-state logic. A command and a tick never arrive in the same cycle
  // (cmd_ready is low in tick cycles), so command-first priority is arbitrary.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    flag_d   = flag_q;
    done_d   = 1'b0;
    if (cmd_hit_i) begin
      case (cmd_op_i)
        OP_LOAD: begin
          if (cmd_val_i != '0) begin
            state_d  = S_RUN;
            remain_d = cmd_val_i;
            flag_d   = 1'b0;
          end else begin
            // Zero-length load expires at once
            state_d  = S_IDLE;
            remain_d = '0;
            done_d   = 1'b1;
            flag_d   = 1'b1;
          end
        end
        OP_PAUSE:  if (state_q == S_RUN)   state_d = S_PAUSE;
        OP_RESUME: if (state_q == S_PAUSE) state_d = S_RUN;
        OP_CLEAR: begin
          state_d  = S_IDLE;
          remain_d = '0;
          flag_d   = 1'b0;
        end
        default: ;
      endcase
    end else if (tick_i && state_q == S_RUN) begin
      if (remain_q > CNT_W'(1)) begin
        remain_d = remain_q - CNT_W'(1);
      end else begin
        state_d  = S_IDLE;
        remain_d = '0;
        done_d   = 1'b1;
        flag_d   = 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    busy_o   = (state_q != S_IDLE);
    done_o   = done_q;
    flag_o   = flag_q;
    remain_o = remain_q;
  end
endmodule

// ---------------------------------------------------------------------------
// Top level
// ---------------------------------------------------------------------------
module sec_timer_ctrl #(
  parameter int CLK_HZ = 50000000,
  parameter int N_CH   = 4,
  parameter int CNT_W  = 8,
  localparam int CHW   = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [CHW-1:0]   cmd_ch_i,
  input  logic [CNT_W-1:0] cmd_val_i,
  output logic             tick_1s_o,
  output logic [N_CH-1:0]  ch_busy_o,
  output logic [N_CH-1:0]  ch_done_o,
  output logic [N_CH-1:0]  ch_flag_o,
  output logic             irq_o,
  input  logic [CHW-1:0]   rd_ch_i,
  output logic [CNT_W-1:0] rd_remain_o
);
  // CLK_HZ=1 still needs a one-bit counter; it simply stays at 0
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] psc_q, psc_d;
  logic          tick_q, tick_d;
  logic          cmd_acc;

  logic [N_CH-1:0][CNT_W-1:0] ch_remain;

  // Prescaler: free-running, never touched by commands
  always_comb begin
    tick_d = (psc_q == PSC_MAX);
    psc_d  = tick_d ? '0 : psc_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      tick_q <= tick_d;
    end
  end

  assign tick_1s_o   = tick_q;
  assign cmd_ready_o = ~tick_q;
  assign cmd_acc     = cmd_valid_i & ~tick_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;
    assign hit = cmd_acc && (cmd_ch_i == CHW'(i));

    sec_timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (tick_q),
      .cmd_hit_i (hit),
      .cmd_op_i  (cmd_op_i),
      .cmd_val_i (cmd_val_i),
      .busy_o    (ch_busy_o[i]),
      .done_o    (ch_done_o[i]),
      .flag_o    (ch_flag_o[i]),
      .remain_o  (ch_remain[i])
    );
  end

  assign irq_o = |ch_flag_o;

  // Readback mux; an out-of-range select (non power-of-two N_CH) reads 0
  always_comb begin
    rd_remain_o = '0;
    for (int i = 0; i < N_CH; i++)
      if (rd_ch_i == CHW'(i)) rd_remain_o = ch_remain[i];
  end
endmodule

// File: tb/tb_sec_timer_ctrl.sv
module tb_sec_timer_ctrl;
  localparam int CLK_HZ = 4;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 8;

  localparam logic [1:0] LOAD = 2'b00, PAUSE = 2'b01, RESUME = 2'b10, CLEAR = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [1:0]       cmd_ch = 2'b00;
  logic [CNT_W-1:0] cmd_val = '0;
  logic             tick;
  logic [N_CH-1:0]  busy, done, flag;
  logic             irq;
  logic [1:0]       rd_ch = 2'b00;
  logic [CNT_W-1:0] rd_remain;

  int n_pass = 0;
  int n_tot  = 0;

  sec_timer_ctrl #(.CLK_HZ(CLK_HZ), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_ch_i    (cmd_ch),
    .cmd_val_i   (cmd_val),
    .tick_1s_o   (tick),
    .ch_busy_o   (busy),
    .ch_done_o   (done),
    .ch_flag_o   (flag),
    .irq_o       (irq),
    .rd_ch_i     (rd_ch),
    .rd_remain_o (rd_remain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Tick: cycle n after reset release has a tick iff n is a multiple of CLK_HZ.
  // Channels: mode 0 idle / 1 counting / 2 paused; a tick seen in a cycle
  // takes one second off each counting channel at the following edge.
  int m_cyc = 0;
  bit m_tick = 0;
  int m_mode [N_CH];
  int m_rem  [N_CH];
  bit m_flag [N_CH];
  bit m_done [N_CH];

  always @(posedge clk or negedge rst_n) begin
    bit prev;
    if (!rst_n) begin
      m_cyc = 0; m_tick = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_mode[i] = 0; m_rem[i] = 0; m_flag[i] = 0; m_done[i] = 0;
      end
    end else begin
      prev = m_tick;
      m_cyc++;
      m_tick = (m_cyc % CLK_HZ) == 0;
      for (int i = 0; i < N_CH; i++) m_done[i] = 0;
      if (cmd_valid && !prev) begin
        int c;
        c = int'(cmd_ch);
        case (cmd_op)
          LOAD: if (cmd_val != 0) begin
                  m_mode[c] = 1; m_rem[c] = int'(cmd_val); m_flag[c] = 0;
                end else begin
                  m_mode[c] = 0; m_rem[c] = 0; m_flag[c] = 1; m_done[c] = 1;
                end
          PAUSE:  if (m_mode[c] == 1) m_mode[c] = 2;
          RESUME: if (m_mode[c] == 2) m_mode[c] = 1;
          default: begin m_mode[c] = 0; m_rem[c] = 0; m_flag[c] = 0; end
        endcase
      end
      if (prev)
        for (int i = 0; i < N_CH; i++)
          if (m_mode[i] == 1) begin
            m_rem[i] = m_rem[i] - 1;
            if (m_rem[i] == 0) begin m_mode[i] = 0; m_done[i] = 1; m_flag[i] = 1; end
          end
    end
  end

  // Compare process, every cycle
  always @(negedge clk) begin
    logic [N_CH-1:0] eb, ed, ef;
    for (int i = 0; i < N_CH; i++) begin
      eb[i] = (m_mode[i] != 0); ed[i] = m_done[i]; ef[i] = m_flag[i];
    end
    chk("m_tick",   32'(tick),      32'(m_tick));
    chk("m_ready",  32'(cmd_ready), 32'(!m_tick));
    chk("m_busy",   32'(busy),      32'(eb));
    chk("m_done",   32'(done),      32'(ed));
    chk("m_flag",   32'(flag),      32'(ef));
    chk("m_irq",    32'(irq),       32'(|ef));
    chk("m_remain", 32'(rd_remain), 32'(m_rem[int'(rd_ch)]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [1:0] op, input int ch, input int val, output int n);
    bit acc;
    cmd_valid = 1'b1; cmd_op = op; cmd_ch = 2'(ch); cmd_val = CNT_W'(val);
    n = 0; acc = 0;
    while (!acc && n < 20) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #2; n++;
    end
    cmd_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_tick_high();
    int n;
    n = 0;
    while (!tick && n < 3 * CLK_HZ) begin step(); n++; end
    if (!tick) chk("tick_timeout", 0, 1);
  endtask

  // returns just after the edge that consumed a tick
  task automatic wait_tick();
    wait_tick_high();
    step();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_irq", 32'(irq), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: tick at cycles 4, 8, 12
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t1_tick", 32'(tick), 32'(k == 4 || k == 8 || k == 12));
      chk("t1_ready", 32'(cmd_ready), 32'(!(k == 4 || k == 8 || k == 12)));
    end

    // 2: LOAD ch0=3, count down, expire, CLEAR
    rd_ch = 2'd0;
    send(LOAD, 0, 3, n);
    chk("t2_busy", 32'(busy[0]), 1);
    chk("t2_rem3", 32'(rd_remain), 3);
    wait_tick(); chk("t2_rem2", 32'(rd_remain), 2);
    wait_tick(); chk("t2_rem1", 32'(rd_remain), 1);
    chk("t2_nodone", 32'(done[0]), 0);
    wait_tick();
    chk("t2_rem0", 32'(rd_remain), 0);
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_flag", 32'(flag[0]), 1);
    chk("t2_irq", 32'(irq), 1);
    step();
    chk("t2_done_once", 32'(done[0]), 0);
    chk("t2_flag_sticky", 32'(flag[0]), 1);
    send(CLEAR, 0, 0, n);
    chk("t2_clr_flag", 32'(flag[0]), 0);
    chk("t2_clr_irq", 32'(irq), 0);

    // 3: request held across a tick cycle
    rd_ch = 2'd1;
    wait_tick_high();
    chk("t3_ready_low", 32'(cmd_ready), 0);
    send(LOAD, 1, 2, n);
    chk("t3_accept_cycles", 32'(n), 2);
    chk("t3_rem", 32'(rd_remain), 2);

    // 4: pause across three ticks, resume, five more ticks to expiry
    send(LOAD, 1, 5, n);
    send(PAUSE, 1, 0, n);
    repeat (3) wait_tick();
    chk("t4_held", 32'(rd_remain), 5);
    chk("t4_busy", 32'(busy[1]), 1);
    send(RESUME, 1, 0, n);
    for (int k = 1; k <= 5; k++) begin
      wait_tick();
      chk("t4_rem", 32'(rd_remain), 32'(5 - k));
      chk("t4_done", 32'(done[1]), 32'(k == 5));
    end

    // 5: zero load and reload while running
    rd_ch = 2'd3;
    send(LOAD, 2, 0, n);
    chk("t5_done2", 32'(done[2]), 1);
    chk("t5_busy2", 32'(busy[2]), 0);
    chk("t5_flag2", 32'(flag[2]), 1);
    send(LOAD, 3, 2, n);
    wait_tick();
    chk("t5_rem1", 32'(rd_remain), 1);
    send(LOAD, 3, 10, n);
    chk("t5_rem10", 32'(rd_remain), 10);
    chk("t5_nodone3", 32'(done[3]), 0);

    // 6: simultaneous expiry, then reset mid-count
    rd_ch = 2'd0;
    wait_tick();
    send(LOAD, 0, 2, n);
    send(LOAD, 1, 2, n);
    wait_tick();
    chk("t6_rem1", 32'(rd_remain), 1);
    wait_tick();
    chk("t6_both_done", 32'(done[1:0]), 32'h3);
    send(LOAD, 0, 5, n);
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_flag", 32'(flag), 0);
    chk("t6_rst_irq", 32'(irq), 0);
    chk("t6_rst_rem", 32'(rd_remain), 0);
    chk("t6_rst_tick", 32'(tick), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t6_tick_after_rst", 32'(tick), 32'(k == 4));
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end
endmodule
